// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for a 16-way decoded select bus: registered index plus one-hot select, hold timeout, one-cycle gap.
// Latency: one cycle from sampled request to visible grant. Once granted, other requests are ignored until the grant is released.
module decoder_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] req,
   input  logic        done,
   output logic        grant_valid,
   output logic [3:0]  grant_index,
   output logic [15:0] grant_out,
   output logic        timeout,
   output logic [7:0]  busy_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic        grant_valid_q, grant_valid_d;
   logic [3:0]  grant_index_q, grant_index_d;
   logic [15:0] grant_out_q, grant_out_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  busy_cnt_q, busy_cnt_d;

   logic        win_found;
   logic [3:0]  win_idx;
   logic [3:0]  cand;
   logic        owner_rel;
   logic        hold_expired;

   // Circular scan starting at ptr; the first set bit wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 0; k < 16; k++) begin
         cand = ptr_q + 4'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign owner_rel    = !enable || done || !req[grant_index_q];
   assign hold_expired = (busy_cnt_q == 8'(MAX_HOLD));

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_valid_d = grant_valid_q;
      grant_index_d = grant_index_q;
      grant_out_d   = grant_out_q;
      timeout_d     = 1'b0;
      busy_cnt_d    = busy_cnt_q;
      case (state_q)
         IDLE: begin
            if (enable && win_found) begin
               state_d       = GRANT;
               grant_valid_d = 1'b1;
               grant_index_d = win_idx;
               grant_out_d   = 16'h0001 << win_idx;
               busy_cnt_d    = 8'd1;
            end else begin
               grant_valid_d = 1'b0;
               grant_out_d   = 16'h0000;
               busy_cnt_d    = 8'd0;
            end
         end
         GRANT: begin
            if (owner_rel || hold_expired) begin
               // A normal release takes precedence, so timeout only flags a forced release.
               state_d       = GAP;
               grant_valid_d = 1'b0;
               grant_out_d   = 16'h0000;
               busy_cnt_d    = 8'd0;
               ptr_d         = grant_index_q + 4'd1;
               timeout_d     = !owner_rel;
            end else begin
               busy_cnt_d = busy_cnt_q + 8'd1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            grant_out_d   = 16'h0000;
            busy_cnt_d    = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= 4'h0;
         grant_valid_q <= 1'b0;
         grant_index_q <= 4'h0;
         grant_out_q   <= 16'h0000;
         timeout_q     <= 1'b0;
         busy_cnt_q    <= 8'd0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_index_q <= grant_index_d;
         grant_out_q   <= grant_out_d;
         timeout_q     <= timeout_d;
         busy_cnt_q    <= busy_cnt_d;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_index = grant_index_q;
   assign grant_out   = grant_out_q;
   assign timeout     = timeout_q;
   assign busy_cnt    = busy_cnt_q;

   always @(posedge clk) begin
      if (rst_n) begin
         assert ($onehot0(grant_out_q))
         else $error("grant_out multi-hot: %h", grant_out_q);
      end
   end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with a short hold limit so the timeout path is reachable.
module tb_decoder_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] req;
   logic        done;
   logic        grant_valid;
   logic [3:0]  grant_index;
   logic [15:0] grant_out;
   logic        timeout;
   logic [7:0]  busy_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .req         (req),
      .done        (done),
      .grant_valid (grant_valid),
      .grant_index (grant_index),
      .grant_out   (grant_out),
      .timeout     (timeout),
      .busy_cnt    (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for grant_valid and returns the number of edges it took.
   task automatic wait_grant(output int n);
      n = 0;
      while (grant_valid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      check("grant_seen", {31'd0, grant_valid}, 32'd1);
   endtask

   task automatic release_done();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rel_valid", {31'd0, grant_valid}, 32'd0);
      check("rel_out", {16'd0, grant_out}, 32'd0);
   endtask

   initial begin
      int n;
      int exp_i;
      rst_n  = 1'b0;
      enable = 1'b0;
      req    = 16'h0000;
      done   = 1'b0;
      #12;
      check("rst_valid", {31'd0, grant_valid}, 32'd0);
      check("rst_index", {28'd0, grant_index}, 32'd0);
      check("rst_out", {16'd0, grant_out}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_busy", {24'd0, busy_cnt}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single requester: one-cycle latency, release, two-cycle regrant.
      req    = 16'h0001;
      enable = 1'b1;
      tick();
      check("t1_valid", {31'd0, grant_valid}, 32'd1);
      check("t1_index", {28'd0, grant_index}, 32'd0);
      check("t1_out", {16'd0, grant_out}, 32'h0001);
      check("t1_busy", {24'd0, busy_cnt}, 32'd1);
      release_done();
      check("t1_gap_busy", {24'd0, busy_cnt}, 32'd0);
      check("t1_gap_timeout", {31'd0, timeout}, 32'd0);
      tick();
      check("t1_idle_valid", {31'd0, grant_valid}, 32'd0);
      tick();
      check("t1_regrant_index", {28'd0, grant_index}, 32'd0);
      check("t1_regrant_out", {16'd0, grant_out}, 32'h0001);

      // Two requesters alternate; ptr=1 after last release so 15 comes first.
      req = 16'h8001;
      release_done();
      for (int g = 0; g < 5; g++) begin
         wait_grant(n);
         check("t2_gap_len", n, 32'd2);
         check("t2_index", {28'd0, grant_index}, (g % 2 == 0) ? 32'd15 : 32'd0);
         check("t2_out", {16'd0, grant_out}, (g % 2 == 0) ? 32'h8000 : 32'h0001);
         release_done();
      end

      // All requesting, ptr=0: strict rotation including the 15 -> 0 wrap.
      req = 16'hFFFF;
      for (int g = 0; g < 17; g++) begin
         exp_i = g % 16;
         wait_grant(n);
         check("t3_index", {28'd0, grant_index}, exp_i);
         check("t3_out", {16'd0, grant_out}, 32'd1 << exp_i);
         if (exp_i == 10) check("t3_out10", {16'd0, grant_out}, 32'h0400);
         tick();
         check("t3_busy2", {24'd0, busy_cnt}, 32'd2);
         release_done();
      end
      req = 16'h0000;

      // Hold timeout: ptr=1 -> requester 5 wins, held 4 cycles, then requester 8.
      req = 16'h0120;
      wait_grant(n);
      check("t4_index", {28'd0, grant_index}, 32'd5);
      for (int c = 1; c <= 4; c++) begin
         check("t4_busy", {24'd0, busy_cnt}, c);
         check("t4_no_timeout", {31'd0, timeout}, 32'd0);
         if (c < 4) tick();
      end
      tick();
      check("t4_rel_valid", {31'd0, grant_valid}, 32'd0);
      check("t4_timeout", {31'd0, timeout}, 32'd1);
      check("t4_rel_busy", {24'd0, busy_cnt}, 32'd0);
      tick();
      check("t4_timeout_clear", {31'd0, timeout}, 32'd0);
      tick();
      check("t4_next_index", {28'd0, grant_index}, 32'd8);
      release_done();
      req = 16'h0000;

      // Enable drop mid-grant of index 3 (ptr=9, wrap); then done at the hold limit.
      req = 16'h0008;
      wait_grant(n);
      check("t5_index", {28'd0, grant_index}, 32'd3);
      tick();
      enable = 1'b0;
      tick();
      check("t5_en_valid", {31'd0, grant_valid}, 32'd0);
      check("t5_en_timeout", {31'd0, timeout}, 32'd0);
      check("t5_en_index_kept", {28'd0, grant_index}, 32'd3);
      tick();
      tick();
      check("t5_disabled_nogrant", {31'd0, grant_valid}, 32'd0);
      enable = 1'b1;
      wait_grant(n);
      tick();
      tick();
      tick();
      check("t5_busy_max", {24'd0, busy_cnt}, 32'd4);
      release_done();
      check("t5_done_at_max_timeout", {31'd0, timeout}, 32'd0);

      // done while idle is ignored.
      req  = 16'h0000;
      done = 1'b1;
      tick();
      tick();
      done = 1'b0;
      check("t5_idle_done", {31'd0, grant_valid}, 32'd0);

      // Asynchronous reset mid-grant, then ptr restarts at 0: bits {2,5} -> 2.
      req = 16'h0004;
      wait_grant(n);
      check("t6_index", {28'd0, grant_index}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", {31'd0, grant_valid}, 32'd0);
      check("t6_async_out", {16'd0, grant_out}, 32'd0);
      check("t6_async_busy", {24'd0, busy_cnt}, 32'd0);
      tick();
      rst_n = 1'b1;
      req   = 16'h0024;
      wait_grant(n);
      check("t6_post_rst_index", {28'd0, grant_index}, 32'd2);
      check("t6_post_rst_out", {16'd0, grant_out}, 32'h0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
